// File: rtl/apb_irq_event_ctrl_pkg.sv
// Shared register map and sleep-sequencer state encoding for apb_irq_event_ctrl.
package apb_irq_event_ctrl_pkg;

    localparam logic [4:0] OFF_IRQ_MASK   = 5'h00;
    localparam logic [4:0] OFF_IRQ_PEND   = 5'h04;
    localparam logic [4:0] OFF_IRQ_CLR    = 5'h08;
    localparam logic [4:0] OFF_EVT_MASK   = 5'h0C;
    localparam logic [4:0] OFF_EVT_PEND   = 5'h10;
    localparam logic [4:0] OFF_EVT_CLR    = 5'h14;
    localparam logic [4:0] OFF_SLEEP_CTRL = 5'h18;
    localparam logic [4:0] OFF_STATUS     = 5'h1C;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_SLEEP     = 2'd2,
        ST_WAKE      = 2'd3
    } sleep_state_e;

endpackage

// File: rtl/apb_irq_event_ctrl_irq_line_bank.sv
// One bank of asynchronous request lines: synchroniser, registered rising-edge
// detect, pending latch with set-over-clear priority, and an enable mask.
module irq_line_bank
    import apb_irq_event_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LINES   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 HRESETn,
    input  logic [NUM_LINES-1:0] lines_i,
    input  logic                 mask_we_i,
    input  logic [NUM_LINES-1:0] mask_wdata_i,
    input  logic [NUM_LINES-1:0] set_i,
    input  logic [NUM_LINES-1:0] clr_i,
    output logic [NUM_LINES-1:0] pend_o,
    output logic [NUM_LINES-1:0] mask_o
);

    logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_q, sync_d;
    logic [NUM_LINES-1:0] prev_q, prev_d;
    logic [NUM_LINES-1:0] edge_q, edge_d;
    logic [NUM_LINES-1:0] pend_q, pend_d;
    logic [NUM_LINES-1:0] mask_q, mask_d;

    // The edge is registered so a pending bit appears one cycle after the
    // last synchroniser stage, keeping a clean flop between sync and latch.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], lines_i};
        prev_d = sync_q[SYNC_STAGES-1];
        edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        pend_d = (pend_q & ~clr_i) | edge_q | set_i;
        mask_d = mask_we_i ? mask_wdata_i : mask_q;
    end

    always_ff @(posedge clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q <= '0;
            prev_q <= '0;
            edge_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

    assign pend_o = pend_q;
    assign mask_o = mask_q;

endmodule

// File: rtl/apb_irq_event_ctrl.sv
// APB interrupt/event controller: two line banks, lowest-index interrupt
// encoder with ack, and a sleep sequencer that gates the core clock.
module apb_irq_event_ctrl
    import apb_irq_event_ctrl_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_LINES      = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned WAKE_CYCLES    = 4
) (
    input  logic                      clk_i,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_LINES-1:0]      irq_i,
    input  logic [NUM_LINES-1:0]      event_i,
    output logic                      irq_req_o,
    output logic [4:0]                irq_id_o,
    input  logic                      irq_ack_i,
    input  logic [4:0]                irq_id_i,
    input  logic                      core_busy_i,
    input  logic                      fetch_enable_i,
    output logic                      fetch_enable_o,
    output logic                      clk_gate_core_o
);

    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

    logic [4:0]           reg_off;
    logic                 addr_err;
    logic                 access;
    logic                 wr;
    logic                 unused_apb;
    logic [NUM_LINES-1:0] wdata;

    logic                 irq_mask_we, evt_mask_we;
    logic [NUM_LINES-1:0] irq_set, irq_clr, evt_set, evt_clr, ack_clr;
    logic [NUM_LINES-1:0] irq_pend, irq_mask, evt_pend, evt_mask;
    logic [NUM_LINES-1:0] irq_act;
    logic                 sleep_req;
    logic                 wake;

    sleep_state_e         state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 clk_gate_q, clk_gate_d;
    logic                 irq_req_q, irq_req_d;
    logic [4:0]           irq_id_q, irq_id_d;
    logic [SYNC_STAGES-1:0] fe_sync_q, fe_sync_d;

    assign reg_off    = {PADDR[4:2], 2'b00};
    assign addr_err   = |PADDR[APB_ADDR_WIDTH-1:5];
    assign access     = PSEL & PENABLE;
    assign wr         = access & PWRITE & ~addr_err;
    assign wdata      = PWDATA[NUM_LINES-1:0];
    assign unused_apb = ^{PADDR[1:0], PWDATA};

    assign PREADY  = 1'b1;
    assign PSLVERR = access & addr_err;

    always_comb begin
        irq_mask_we = wr && (reg_off == OFF_IRQ_MASK);
        evt_mask_we = wr && (reg_off == OFF_EVT_MASK);
        irq_set     = (wr && (reg_off == OFF_IRQ_PEND)) ? wdata : '0;
        evt_set     = (wr && (reg_off == OFF_EVT_PEND)) ? wdata : '0;
        evt_clr     = (wr && (reg_off == OFF_EVT_CLR))  ? wdata : '0;
        sleep_req   = wr && (reg_off == OFF_SLEEP_CTRL) && PWDATA[0];
        ack_clr     = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            ack_clr[i] = irq_ack_i && (irq_id_i == 5'(i));
        end
        irq_clr = ((wr && (reg_off == OFF_IRQ_CLR)) ? wdata : '0) | ack_clr;
    end

    irq_line_bank #(
        .NUM_LINES   (NUM_LINES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_bank (
        .clk_i        (clk_i),
        .HRESETn      (HRESETn),
        .lines_i      (irq_i),
        .mask_we_i    (irq_mask_we),
        .mask_wdata_i (wdata),
        .set_i        (irq_set),
        .clr_i        (irq_clr),
        .pend_o       (irq_pend),
        .mask_o       (irq_mask)
    );

    irq_line_bank #(
        .NUM_LINES   (NUM_LINES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_evt_bank (
        .clk_i        (clk_i),
        .HRESETn      (HRESETn),
        .lines_i      (event_i),
        .mask_we_i    (evt_mask_we),
        .mask_wdata_i (wdata),
        .set_i        (evt_set),
        .clr_i        (evt_clr),
        .pend_o       (evt_pend),
        .mask_o       (evt_mask)
    );

    assign irq_act = irq_pend & irq_mask;
    assign wake    = (|irq_act) | (|(evt_pend & evt_mask));

    always_comb begin
        irq_req_d = |irq_act;
        irq_id_d  = '0;
        for (int unsigned i = NUM_LINES; i > 0; i--) begin
            if (irq_act[i-1]) irq_id_d = 5'(i - 1);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fe_sync_d = {fe_sync_q[SYNC_STAGES-2:0], fetch_enable_i};
        case (state_q)
            ST_RUN:       if (sleep_req) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
                if (wake)              state_d = ST_RUN;
                else if (!core_busy_i) state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (wake) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - 8'd1;
            end
            default:      state_d = ST_RUN;
        endcase
        // Gate enable comes from its own flop so the core clock enable is glitch-free.
        clk_gate_d = (state_d != ST_SLEEP);
    end

    always_ff @(posedge clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            clk_gate_q <= 1'b1;
            irq_req_q  <= 1'b0;
            irq_id_q   <= '0;
            fe_sync_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_gate_q <= clk_gate_d;
            irq_req_q  <= irq_req_d;
            irq_id_q   <= irq_id_d;
            fe_sync_q  <= fe_sync_d;
        end
    end

    assign irq_req_o       = irq_req_q;
    assign irq_id_o        = irq_id_q;
    assign clk_gate_core_o = clk_gate_q;
    assign fetch_enable_o  = fe_sync_q[SYNC_STAGES-1] &
                             ((state_q == ST_RUN) || (state_q == ST_WAIT_IDLE));

    always_comb begin
        PRDATA = '0;
        if (PSEL && !addr_err) begin
            case (reg_off)
                OFF_IRQ_MASK: PRDATA = 32'(irq_mask);
                OFF_IRQ_PEND: PRDATA = 32'(irq_pend);
                OFF_EVT_MASK: PRDATA = 32'(evt_mask);
                OFF_EVT_PEND: PRDATA = 32'(evt_pend);
                OFF_STATUS:   PRDATA = {15'b0, irq_req_q, 3'b0, irq_id_q, 6'b0, state_q};
                default:      PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_irq_event_ctrl.sv
// Self-checking bench for apb_irq_event_ctrl: register vector table, directed
// interrupt/sleep sequences, and a randomized run against a latency-rule model.
module tb_apb_irq_event_ctrl;

    logic        clk_i = 1'b0;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] irq_i, event_i;
    logic        irq_req_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;
    logic        core_busy_i, fetch_enable_i;
    logic        fetch_enable_o, clk_gate_core_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    apb_irq_event_ctrl #(
        .APB_ADDR_WIDTH (12),
        .NUM_LINES      (32),
        .SYNC_STAGES    (2),
        .WAKE_CYCLES    (4)
    ) dut (
        .clk_i           (clk_i),
        .HRESETn         (HRESETn),
        .PADDR           (PADDR),
        .PWDATA          (PWDATA),
        .PWRITE          (PWRITE),
        .PSEL            (PSEL),
        .PENABLE         (PENABLE),
        .PRDATA          (PRDATA),
        .PREADY          (PREADY),
        .PSLVERR         (PSLVERR),
        .irq_i           (irq_i),
        .event_i         (event_i),
        .irq_req_o       (irq_req_o),
        .irq_id_o        (irq_id_o),
        .irq_ack_i       (irq_ack_i),
        .irq_id_i        (irq_id_i),
        .core_busy_i     (core_busy_i),
        .fetch_enable_i  (fetch_enable_i),
        .fetch_enable_o  (fetch_enable_o),
        .clk_gate_core_o (clk_gate_core_o)
    );

    typedef struct {
        logic        wr;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err);
        @(negedge clk_i);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge clk_i);
        PENABLE = 1'b1;
        #1;
        rd  = PRDATA;
        err = PSLVERR;
        @(posedge clk_i);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    function automatic logic [4:0] low_id(input logic [31:0] v);
        logic [31:0] iso;
        if (v == 32'd0) return 5'd0;
        iso = v & (~v + 32'd1);
        return 5'($clog2(iso));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          low_cnt;
        logic [31:0] mask_m, pend_m, h0, h1, h2, h3, h4, set_v, clr_v, act_v;
        logic        req_m;
        logic [4:0]  id_m;

        tbl[0]  = '{1'b0, 12'h000, 32'h0,          12'h000, 32'h0,          1'b0};
        tbl[1]  = '{1'b0, 12'h000, 32'h0,          12'h004, 32'h0,          1'b0};
        tbl[2]  = '{1'b0, 12'h000, 32'h0,          12'h008, 32'h0,          1'b0};
        tbl[3]  = '{1'b0, 12'h000, 32'h0,          12'h00C, 32'h0,          1'b0};
        tbl[4]  = '{1'b0, 12'h000, 32'h0,          12'h010, 32'h0,          1'b0};
        tbl[5]  = '{1'b0, 12'h000, 32'h0,          12'h014, 32'h0,          1'b0};
        tbl[6]  = '{1'b0, 12'h000, 32'h0,          12'h018, 32'h0,          1'b0};
        tbl[7]  = '{1'b0, 12'h000, 32'h0,          12'h01C, 32'h0,          1'b0};
        tbl[8]  = '{1'b0, 12'h000, 32'h0,          12'h020, 32'h0,          1'b1};
        tbl[9]  = '{1'b1, 12'h000, 32'hA5A5_F10F,  12'h000, 32'hA5A5_F10F,  1'b0};
        tbl[10] = '{1'b1, 12'h004, 32'h0000_0100,  12'h004, 32'h0000_0100,  1'b0};
        tbl[11] = '{1'b0, 12'h000, 32'h0,          12'h01C, 32'h0001_0800,  1'b0};
        tbl[12] = '{1'b1, 12'h008, 32'hFFFF_FFFF,  12'h004, 32'h0,          1'b0};
        tbl[13] = '{1'b0, 12'h000, 32'h0,          12'h01C, 32'h0,          1'b0};
        tbl[14] = '{1'b1, 12'h00C, 32'h0000_00FF,  12'h00C, 32'h0000_00FF,  1'b0};
        tbl[15] = '{1'b1, 12'h010, 32'h0000_0003,  12'h010, 32'h0000_0003,  1'b0};
        tbl[16] = '{1'b1, 12'h014, 32'h0000_0001,  12'h010, 32'h0000_0002,  1'b0};
        tbl[17] = '{1'b1, 12'h024, 32'h0000_FFFF,  12'h004, 32'h0,          1'b0};
        tbl[18] = '{1'b1, 12'h014, 32'h0000_0002,  12'h010, 32'h0,          1'b0};
        tbl[19] = '{1'b1, 12'h000, 32'h0,          12'h000, 32'h0,          1'b0};
        tbl[20] = '{1'b1, 12'h00C, 32'h0,          12'h00C, 32'h0,          1'b0};

        HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        irq_i = '0; event_i = '0; irq_ack_i = 1'b0; irq_id_i = '0;
        core_busy_i = 1'b0; fetch_enable_i = 1'b1;

        // Reset state
        #12;
        chk("rst_irq_req", 32'(irq_req_o), 32'd0);
        chk("rst_irq_id", 32'(irq_id_o), 32'd0);
        chk("rst_clk_gate", 32'(clk_gate_core_o), 32'd1);
        chk("rst_fetch_en", 32'(fetch_enable_o), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("pready", 32'(PREADY), 32'd1);
        @(negedge clk_i);
        HRESETn = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("fetch_en_after_sync", 32'(fetch_enable_o), 32'd1);

        // Register vector table
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].wr) xfer(1'b1, tbl[i].wa, tbl[i].wd, rd, err);
            xfer(1'b0, tbl[i].ra, 32'h0, rd, err);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_slverr", i), 32'(err), 32'(tbl[i].err));
        end

        // Two simultaneous edges: latency, then ack ordering
        xfer(1'b1, 12'h000, 32'h0000_0030, rd, err);
        @(negedge clk_i);
        irq_i[5:4] = 2'b11;
        @(posedge clk_i);
        #1;
        irq_i[5:4] = 2'b00;
        repeat (3) @(posedge clk_i);
        #1;
        chk("lat_req_early", 32'(irq_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("lat_req", 32'(irq_req_o), 32'd1);
        chk("lat_id4", 32'(irq_id_o), 32'd4);
        @(negedge clk_i);
        irq_ack_i = 1'b1; irq_id_i = 5'd4;
        @(posedge clk_i);
        #1;
        irq_ack_i = 1'b0;
        chk("ack4_id_lag", 32'(irq_id_o), 32'd4);
        @(posedge clk_i);
        #1;
        chk("ack4_req", 32'(irq_req_o), 32'd1);
        chk("ack4_next_id5", 32'(irq_id_o), 32'd5);
        @(negedge clk_i);
        irq_ack_i = 1'b1; irq_id_i = 5'd5;
        @(posedge clk_i);
        #1;
        irq_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("ack5_req_off", 32'(irq_req_o), 32'd0);
        chk("ack5_id_zero", 32'(irq_id_o), 32'd0);

        // Masked line still latches; unmask raises request one cycle later
        @(negedge clk_i);
        irq_i[3] = 1'b1;
        @(posedge clk_i);
        #1;
        irq_i[3] = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        chk("masked_req", 32'(irq_req_o), 32'd0);
        xfer(1'b0, 12'h004, 32'h0, rd, err);
        chk("masked_pend", rd, 32'h0000_0008);
        xfer(1'b1, 12'h000, 32'h0000_0038, rd, err);
        chk("unmask_req_lag", 32'(irq_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("unmask_req", 32'(irq_req_o), 32'd1);
        chk("unmask_id3", 32'(irq_id_o), 32'd3);
        xfer(1'b1, 12'h008, 32'h0000_0008, rd, err);
        xfer(1'b1, 12'h000, 32'h0, rd, err);

        // Edge set and software clear on the same edge: set wins
        @(negedge clk_i);
        irq_i[7] = 1'b1;
        @(negedge clk_i);
        irq_i[7] = 1'b0;
        xfer(1'b1, 12'h008, 32'h0000_0080, rd, err);
        xfer(1'b0, 12'h004, 32'h0, rd, err);
        chk("set_beats_clr", rd, 32'h0000_0080);
        xfer(1'b1, 12'h008, 32'h0000_0080, rd, err);
        xfer(1'b0, 12'h004, 32'h0, rd, err);
        chk("clr_alone", rd, 32'h0);

        // Sleep request with an enabled interrupt pending aborts back to RUN
        xfer(1'b1, 12'h000, 32'h0000_0001, rd, err);
        xfer(1'b1, 12'h004, 32'h0000_0001, rd, err);
        core_busy_i = 1'b0;
        xfer(1'b1, 12'h018, 32'h0000_0001, rd, err);
        low_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i);
            #1;
            if (clk_gate_core_o == 1'b0) low_cnt++;
        end
        chk("abort_never_gated", 32'(low_cnt), 32'd0);
        xfer(1'b0, 12'h01C, 32'h0, rd, err);
        chk("abort_status", rd & 32'h3, 32'd0);
        xfer(1'b1, 12'h008, 32'h0000_0001, rd, err);
        xfer(1'b1, 12'h000, 32'h0, rd, err);

        // Sleep: held in WAIT_IDLE while busy, then gated, woken by an event
        xfer(1'b1, 12'h00C, 32'h0000_0001, rd, err);
        core_busy_i = 1'b1;
        xfer(1'b1, 12'h018, 32'h0000_0001, rd, err);
        repeat (10) @(posedge clk_i);
        #1;
        chk("busy_gate_on", 32'(clk_gate_core_o), 32'd1);
        chk("busy_fetch_on", 32'(fetch_enable_o), 32'd1);
        xfer(1'b0, 12'h01C, 32'h0, rd, err);
        chk("busy_wait_idle", rd & 32'h3, 32'd1);
        @(negedge clk_i);
        core_busy_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("sleep_gated", 32'(clk_gate_core_o), 32'd0);
        chk("sleep_fetch_off", 32'(fetch_enable_o), 32'd0);
        xfer(1'b0, 12'h01C, 32'h0, rd, err);
        chk("sleep_status", rd & 32'h3, 32'd2);
        @(negedge clk_i);
        event_i[0] = 1'b1;
        @(posedge clk_i);
        #1;
        event_i[0] = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("wake_gate_still_off", 32'(clk_gate_core_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("wake_gate_on", 32'(clk_gate_core_o), 32'd1);
        chk("wake_fetch_off", 32'(fetch_enable_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("wake_fetch_still_off", 32'(fetch_enable_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("wake_fetch_on", 32'(fetch_enable_o), 32'd1);
        xfer(1'b1, 12'h014, 32'h0000_0001, rd, err);
        xfer(1'b0, 12'h01C, 32'h0, rd, err);
        chk("wake_status_run", rd & 32'h3, 32'd0);

        // Asynchronous reset while asleep
        xfer(1'b1, 12'h018, 32'h0000_0001, rd, err);
        @(posedge clk_i);
        #1;
        chk("pre_rst_gated", 32'(clk_gate_core_o), 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_sleep_gate", 32'(clk_gate_core_o), 32'd1);
        @(negedge clk_i);
        HRESETn = 1'b1;
        xfer(1'b0, 12'h01C, 32'h0, rd, err);
        chk("rst_mid_sleep_status", rd, 32'd0);

        // Randomized interrupt traffic against the latency-rule model
        mask_m = $urandom | 32'h0000_0001;
        xfer(1'b1, 12'h000, mask_m, rd, err);
        xfer(1'b1, 12'h008, 32'hFFFF_FFFF, rd, err);
        @(posedge clk_i);
        pend_m = '0; req_m = 1'b0; id_m = '0;
        h0 = '0; h1 = '0; h2 = '0; h3 = '0; h4 = '0;
        @(negedge clk_i);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h004;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            irq_i     = $urandom & $urandom & $urandom;
            irq_ack_i = ($urandom_range(0, 2) == 0);
            irq_id_i  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : id_m;
            #1;
            chk("rnd_req", 32'(irq_req_o), 32'(req_m));
            chk("rnd_id", 32'(irq_id_o), 32'(id_m));
            chk("rnd_pend", PRDATA, pend_m);
            @(posedge clk_i);
            act_v = pend_m & mask_m;
            req_m = |act_v;
            id_m  = low_id(act_v);
            h4 = h3; h3 = h2; h2 = h1; h1 = h0; h0 = irq_i;
            // A line sampled high after a low sample sets pending three edges later.
            set_v  = h3 & ~h4;
            clr_v  = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;
            pend_m = (pend_m & ~clr_v) | set_v;
        end
        @(negedge clk_i);
        PSEL = 1'b0; irq_ack_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
